// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-RAM arbiter:
// FSM states, latched request bundle, range/alignment check.
package dmem_ctrl_pkg;

  localparam int DW = 32;
  localparam logic [DW-1:0] MEM_TOP_DEF = 32'hFFF;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  typedef struct packed {
    logic          we;
    logic          word;
    logic [DW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  // Last touched byte is computed one bit wider so that
  // a word at the top of the address space wraps into
  // the out-of-range case instead of back to zero.
  function automatic logic access_err(
    input logic          word,
    input logic [DW-1:0] addr,
    input logic [DW-1:0] top
  );
    logic [DW:0] last;
    logic        mis;
    last = {1'b0, addr} + {{(DW-1){1'b0}}, word, word};
    mis  = word & (addr[1:0] != 2'b00);
    return mis | (last > {1'b0, top});
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester port of the data-RAM arbiter.
// master = requester side, slave = arbiter side.
interface dmem_req_if
  import dmem_ctrl_pkg::*;
#(
  parameter int WIDTH = DW
);

  logic             valid;
  logic             ready;
  logic             we;
  logic             word;
  logic [WIDTH-1:0] addr;
  logic [WIDTH-1:0] wdata;
  logic             rvalid;
  logic [WIDTH-1:0] rdata;
  logic             err;

  modport master (
    output valid,
    output we,
    output word,
    output addr,
    output wdata,
    input  ready,
    input  rvalid,
    input  rdata,
    input  err
  );

  modport slave (
    input  valid,
    input  we,
    input  word,
    input  addr,
    input  wdata,
    output ready,
    output rvalid,
    output rdata,
    output err
  );

endinterface

// File: rtl/dmem_arbiter_rr.sv
// 2-way round-robin grant: valid_i[1:0] -> grant_o[1:0].
// advance_i moves the pointer past the granted port.
module rr_arbiter2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] valid_i,
  input  logic       advance_i,
  output logic [1:0] grant_o
);

  // 1 = port 1 was granted last, so port 0 wins a tie.
  logic last_q;

  always_comb begin
    grant_o = 2'b00;
    unique case (valid_i)
      2'b11:   grant_o = last_q ? 2'b01 : 2'b10;
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else if (advance_i) begin
      last_q <= grant_o[1];
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data RAM between CPU (req0) and
// loader/debug (req1): rr grant, error check, 1-cycle resp.
module dmem_arbiter
  import dmem_ctrl_pkg::*;
#(
  parameter int             WIDTH   = DW,
  parameter logic [WIDTH-1:0] MEM_TOP = MEM_TOP_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  dmem_req_if.slave        req0,
  dmem_req_if.slave        req1,
  output logic             mem_we_o,
  output logic             mem_word_o,
  output logic [WIDTH-1:0] mem_addr_o,
  output logic [WIDTH-1:0] mem_wdata_o,
  input  logic [WIDTH-1:0] mem_rdata_i
);

  state_t           state_q;
  req_t             req_q;
  logic             err_q;
  logic             gnt_q;
  logic [1:0]       rvalid_q;
  logic [WIDTH-1:0] rdata_q;
  logic             rerr_q;

  logic [1:0]       valid;
  logic [1:0]       grant;
  logic [1:0]       ready;
  logic             idle;
  logic             acc;
  logic             accept;
  req_t             sel;
  logic [WIDTH-1:0] load_val;

  assign valid = {req1.valid, req0.valid};
  assign idle  = (state_q == IDLE);
  assign acc   = (state_q == ACCESS);

  rr_arbiter2 u_rr (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .valid_i   (valid),
    .advance_i (accept),
    .grant_o   (grant)
  );

  // No handshake completes while reset is held.
  assign ready  = grant & {2{idle & ~rst_i}};
  assign accept = |ready;

  assign req0.ready = ready[0];
  assign req1.ready = ready[1];

  always_comb begin
    sel = '0;
    if (ready[1]) begin
      sel.we    = req1.we;
      sel.word  = req1.word;
      sel.addr  = req1.addr;
      sel.wdata = req1.wdata;
    end else begin
      sel.we    = req0.we;
      sel.word  = req0.word;
      sel.addr  = req0.addr;
      sel.wdata = req0.wdata;
    end
  end

  // Reset in ACCESS must suppress the RAM write
  // in that very cycle, hence the rst_i term.
  assign mem_we_o    = acc & req_q.we & ~err_q & ~rst_i;
  assign mem_word_o  = acc & req_q.word;
  assign mem_addr_o  = acc ? req_q.addr  : '0;
  assign mem_wdata_o = acc ? req_q.wdata : '0;

  // RAM returns the addressed byte in [7:0].
  assign load_val = req_q.word ? mem_rdata_i :
    {{(WIDTH-8){mem_rdata_i[7]}}, mem_rdata_i[7:0]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      req_q    <= '0;
      err_q    <= 1'b0;
      gnt_q    <= 1'b0;
      rvalid_q <= 2'b00;
      rdata_q  <= '0;
      rerr_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            req_q   <= sel;
            err_q   <= access_err(sel.word, sel.addr,
                                  MEM_TOP);
            gnt_q   <= ready[1];
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          rvalid_q <= {gnt_q, ~gnt_q};
          rdata_q  <= (req_q.we | err_q) ? '0 : load_val;
          rerr_q   <= err_q;
          state_q  <= RESP;
        end
        RESP: begin
          rvalid_q <= 2'b00;
          rdata_q  <= '0;
          rerr_q   <= 1'b0;
          req_q    <= '0;
          err_q    <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req0.rvalid = rvalid_q[0];
  assign req0.rdata  = rvalid_q[0] ? rdata_q : '0;
  assign req0.err    = rvalid_q[0] & rerr_q;

  assign req1.rvalid = rvalid_q[1];
  assign req1.rdata  = rvalid_q[1] ? rdata_q : '0;
  assign req1.err    = rvalid_q[1] & rerr_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: per-cycle reference model
// plus directed transactions with literal expectations.
module tb_dmem_arbiter;
  import dmem_ctrl_pkg::*;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  dmem_req_if req0_if ();
  dmem_req_if req1_if ();

  logic        mem_we_o;
  logic        mem_word_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;

  dmem_arbiter dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req0        (req0_if),
    .req1        (req1_if),
    .mem_we_o    (mem_we_o),
    .mem_word_o  (mem_word_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] init_byte(int i);
    logic [31:0] w;
    w = 32'hDEADBEEF;
    if (i >= 'h10 && i <= 'h13) return w[8*(i-'h10) +: 8];
    if (i >= 'h40 && i <= 'h43) return 8'hA5;
    return 8'h00;
  endfunction

  // RAM: combinational read, write on posedge.
  logic [7:0]  ram [0:4095];
  logic [11:0] ra;
  always_comb begin
    ra = mem_addr_o[11:0];
    if (mem_word_o)
      mem_rdata_i = {ram[ra + 12'd3], ram[ra + 12'd2],
                     ram[ra + 12'd1], ram[ra]};
    else
      mem_rdata_i = {24'h0, ram[ra]};
  end

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = init_byte(i);
    forever begin
      @(posedge clk_i);
      if (mem_we_o) begin
        ram[mem_addr_o[11:0]] = mem_wdata_o[7:0];
        if (mem_word_o) begin
          ram[mem_addr_o[11:0] + 12'd1] = mem_wdata_o[15:8];
          ram[mem_addr_o[11:0] + 12'd2] = mem_wdata_o[23:16];
          ram[mem_addr_o[11:0] + 12'd3] = mem_wdata_o[31:24];
        end
      end
    end
  end

  // Reference model state: m_age counts cycles since the
  // accept edge (0 = nothing in flight).
  logic [7:0]  sh [0:4095];
  int          m_age;
  int          m_port;
  int          m_last;
  logic        m_we, m_word, m_err;
  logic [31:0] m_addr, m_wdata, m_rdata;
  int          we_cnt = 0;
  bit          both_ready = 0;
  int          gnt_log [$];

  function automatic logic ref_err(logic w, logic [31:0] a);
    longint last;
    last = longint'(a) + (w ? 3 : 0);
    if (w && a[1:0] != 2'b00) return 1'b1;
    return last > 64'hFFF;
  endfunction

  initial begin : model
    logic [1:0]  v, rd, e_rd;
    logic        e_rv;
    int          a;
    for (int i = 0; i < 4096; i++) sh[i] = init_byte(i);
    m_age  = 0;
    m_last = 1;
    forever begin
      @(negedge clk_i);
      chk("mem_we", mem_we_o,
          m_age == 1 && m_we && !m_err && !rst_i);
      chk("mem_word", mem_word_o, m_age == 1 && m_word);
      chk("mem_addr", mem_addr_o,
          m_age == 1 ? m_addr : 32'h0);
      chk("mem_wdata", mem_wdata_o,
          m_age == 1 ? m_wdata : 32'h0);
      e_rv = (m_age == 2 && m_port == 0);
      chk("rvalid0", req0_if.rvalid, e_rv);
      chk("rdata0", req0_if.rdata, e_rv ? m_rdata : 0);
      chk("err0", req0_if.err, e_rv && m_err);
      e_rv = (m_age == 2 && m_port == 1);
      chk("rvalid1", req1_if.rvalid, e_rv);
      chk("rdata1", req1_if.rdata, e_rv ? m_rdata : 0);
      chk("err1", req1_if.err, e_rv && m_err);
      v  = {req1_if.valid, req0_if.valid};
      rd = {req1_if.ready, req0_if.ready};
      e_rd = 2'b00;
      if (m_age == 0) begin
        if (v == 2'b11) e_rd = (m_last == 1) ? 2'b01 : 2'b10;
        else e_rd = v;
      end
      if (!rst_i) chk("ready", rd, e_rd);
      if (rd == 2'b11) both_ready = 1;
      if (mem_we_o) we_cnt++;
      if (!rst_i && (rd & v) != 2'b00) gnt_log.push_back(rd[1]);
      // what the next edge does
      if (rst_i) begin
        m_age  = 0;
        m_last = 1;
      end else if (m_age == 1) begin
        if (m_we && !m_err) begin
          a = m_addr[11:0];
          sh[a] = m_wdata[7:0];
          if (m_word) begin
            sh[a+1] = m_wdata[15:8];
            sh[a+2] = m_wdata[23:16];
            sh[a+3] = m_wdata[31:24];
          end
        end
        m_age = 2;
      end else if (m_age == 2) begin
        m_age = 0;
      end else if ((e_rd & v) != 2'b00) begin
        m_port = e_rd[1] ? 1 : 0;
        if (m_port == 1) begin
          m_we = req1_if.we; m_word = req1_if.word;
          m_addr = req1_if.addr; m_wdata = req1_if.wdata;
        end else begin
          m_we = req0_if.we; m_word = req0_if.word;
          m_addr = req0_if.addr; m_wdata = req0_if.wdata;
        end
        m_err = ref_err(m_word, m_addr);
        m_rdata = 32'h0;
        if (!m_we && !m_err) begin
          a = m_addr[11:0];
          if (m_word)
            m_rdata = {sh[a+3], sh[a+2], sh[a+1], sh[a]};
          else
            m_rdata = {{24{sh[a][7]}}, sh[a]};
        end
        m_last = m_port;
        m_age  = 1;
      end
    end
  end

  task automatic set_req(input int p, input logic vl,
                         input logic we, input logic wd,
                         input logic [31:0] ad,
                         input logic [31:0] wdt);
    if (p == 1) begin
      req1_if.valid = vl; req1_if.we = we;
      req1_if.word = wd; req1_if.addr = ad;
      req1_if.wdata = wdt;
    end else begin
      req0_if.valid = vl; req0_if.we = we;
      req0_if.word = wd; req0_if.addr = ad;
      req0_if.wdata = wdt;
    end
  endtask

  function automatic logic get_ready(int p);
    return p == 1 ? req1_if.ready : req0_if.ready;
  endfunction

  function automatic logic get_rv(int p);
    return p == 1 ? req1_if.rvalid : req0_if.rvalid;
  endfunction

  task automatic do_req(input int p, input logic we,
                        input logic wd,
                        input logic [31:0] ad,
                        input logic [31:0] wdt,
                        output logic [31:0] rdata,
                        output logic err,
                        output logic [31:0] maddr);
    logic got;
    got   = 1'b0;
    rdata = 32'h0;
    err   = 1'b0;
    maddr = 32'h0;
    @(posedge clk_i);
    #1 set_req(p, 1'b1, we, wd, ad, wdt);
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk_i);
      got = get_ready(p);
    end
    chk("accept", got, 1'b1);
    @(posedge clk_i);
    #1 set_req(p, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    if (!got) return;
    @(negedge clk_i);
    maddr = mem_addr_o;
    @(negedge clk_i);
    chk("rvalid_latency", get_rv(p), 1'b1);
    if (p == 1) begin
      rdata = req1_if.rdata; err = req1_if.err;
    end else begin
      rdata = req0_if.rdata; err = req0_if.err;
    end
  endtask

  task automatic do_reset();
    @(posedge clk_i);
    #1 rst_i = 1'b1;
    @(posedge clk_i);
    #1 rst_i = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] r, ma, acc;
    logic        e;
    int          w0, g0, acc_rv;
    set_req(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    acc = {mem_we_o, mem_word_o, |mem_addr_o, |mem_wdata_o,
           req0_if.rvalid, req1_if.rvalid,
           |req0_if.rdata, |req1_if.rdata,
           req0_if.err, req1_if.err};
    chk("reset_outputs", acc, 32'h0);

    // single word load on port 0
    do_req(0, 1'b0, 1'b1, 32'h10, 32'h0, r, e, ma);
    chk("load_maddr", ma, 32'h10);
    chk("load_rdata", r, 32'hDEADBEEF);
    chk("load_err", e, 1'b0);

    // byte store then byte load on port 1
    w0 = we_cnt;
    do_req(1, 1'b1, 1'b0, 32'h20, 32'hF3, r, e, ma);
    chk("bstore_we_cycles", we_cnt - w0, 1);
    chk("bstore_rdata", r, 32'h0);
    chk("bstore_err", e, 1'b0);
    chk("bstore_ram", ram[12'h20], 8'hF3);
    do_req(1, 1'b0, 1'b0, 32'h20, 32'h0, r, e, ma);
    chk("bload_sext", r, 32'hFFFFFFF3);

    // contention from reset: order 0,1,0,1
    do_reset();
    g0 = gnt_log.size();
    fork
      begin
        logic [31:0] r0, m0;
        logic        e0;
        do_req(0, 1'b0, 1'b1, 32'h10, 32'h0, r0, e0, m0);
        chk("cont_p0_a", r0, 32'hDEADBEEF);
        do_req(0, 1'b0, 1'b1, 32'h10, 32'h0, r0, e0, m0);
        chk("cont_p0_b", r0, 32'hDEADBEEF);
      end
      begin
        logic [31:0] r1, m1;
        logic        e1;
        do_req(1, 1'b0, 1'b0, 32'h20, 32'h0, r1, e1, m1);
        chk("cont_p1_a", r1, 32'hFFFFFFF3);
        do_req(1, 1'b0, 1'b0, 32'h20, 32'h0, r1, e1, m1);
        chk("cont_p1_b", r1, 32'hFFFFFFF3);
      end
    join
    chk("cont_count", gnt_log.size() - g0, 4);
    if (gnt_log.size() - g0 >= 4) begin
      chk("cont_g0", gnt_log[g0],   0);
      chk("cont_g1", gnt_log[g0+1], 1);
      chk("cont_g2", gnt_log[g0+2], 0);
      chk("cont_g3", gnt_log[g0+3], 1);
    end

    // error responses and range boundaries
    do_req(0, 1'b0, 1'b1, 32'h11, 32'h0, r, e, ma);
    chk("mis_err", e, 1'b1);
    chk("mis_rdata", r, 32'h0);
    w0 = we_cnt;
    do_req(0, 1'b1, 1'b1, 32'hFFE, 32'h55AA55AA, r, e, ma);
    chk("oor_store_err", e, 1'b1);
    chk("oor_store_we", we_cnt - w0, 0);
    do_req(1, 1'b0, 1'b0, 32'h1000, 32'h0, r, e, ma);
    chk("oor_byte_err", e, 1'b1);
    do_req(1, 1'b1, 1'b0, 32'hFFF, 32'h80, r, e, ma);
    chk("top_byte_err", e, 1'b0);
    do_req(1, 1'b0, 1'b0, 32'hFFF, 32'h0, r, e, ma);
    chk("top_byte_load", r, 32'hFFFFFF80);
    do_req(0, 1'b1, 1'b1, 32'hFFC, 32'hCAFEF00D, r, e, ma);
    chk("top_word_err", e, 1'b0);
    do_req(0, 1'b0, 1'b1, 32'hFFC, 32'h0, r, e, ma);
    chk("top_word_load", r, 32'hCAFEF00D);
    do_req(0, 1'b0, 1'b1, 32'hFFFFFFFC, 32'h0, r, e, ma);
    chk("wrap_err", e, 1'b1);

    // reset while a store sits in ACCESS
    w0 = we_cnt;
    @(posedge clk_i);
    #1 set_req(0, 1'b1, 1'b1, 1'b1, 32'h40, 32'h12345678);
    e = 1'b0;
    for (int i = 0; i < 20 && !e; i++) begin
      @(negedge clk_i);
      e = req0_if.ready;
    end
    chk("rst_accept", e, 1'b1);
    @(posedge clk_i);
    #1 rst_i = 1'b1;
    set_req(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk_i);
    chk("rst_we_low", mem_we_o, 1'b0);
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    acc_rv = 0;
    repeat (4) begin
      @(negedge clk_i);
      acc_rv += req0_if.rvalid + req1_if.rvalid;
    end
    chk("rst_no_rvalid", acc_rv, 0);
    chk("rst_we_cycles", we_cnt - w0, 0);
    chk("rst_ram", {ram[12'h43], ram[12'h42],
                    ram[12'h41], ram[12'h40]}, 32'hA5A5A5A5);
    g0 = gnt_log.size();
    fork
      begin
        logic [31:0] r0, m0;
        logic        e0;
        do_req(0, 1'b0, 1'b1, 32'h40, 32'h0, r0, e0, m0);
        chk("post_rst_p0", r0, 32'hA5A5A5A5);
      end
      begin
        logic [31:0] r1, m1;
        logic        e1;
        do_req(1, 1'b0, 1'b1, 32'h10, 32'h0, r1, e1, m1);
        chk("post_rst_p1", r1, 32'hDEADBEEF);
      end
    join
    chk("post_rst_cnt", gnt_log.size() - g0, 2);
    if (gnt_log.size() - g0 >= 1)
      chk("post_rst_first", gnt_log[g0], 0);

    // idle for 10 cycles
    acc = 32'h0;
    repeat (10) begin
      @(negedge clk_i);
      acc = acc | mem_addr_o | mem_wdata_o
                | req0_if.rdata | req1_if.rdata
                | {26'h0, mem_we_o, mem_word_o,
                   req0_if.rvalid, req1_if.rvalid,
                   req0_if.ready | req0_if.err,
                   req1_if.ready | req1_if.err};
    end
    chk("idle_outputs", acc, 32'h0);
    chk("idle_state", dut.state_q, IDLE);
    chk("never_both_ready", both_ready, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
